pipeif_fetch: RTL

Instruction-fetch stage of the five-stage pipeline. It sits directly upstream of the decode stage. It owns the PC register, selects the next PC from the decode stage's `pcsource`/`bpc`/`jpc`/`da`, and fetches from a variable-latency instruction memory through a req/ack handshake. It drives the IF/ID pipeline register (`dpc4`, `inst`). The stage honours the decode stall `wpcir` and implements the one-instruction branch delay slot: there is no flush.

---
 rtl/pipeif_fetch_if.sv | 30 +++
 rtl/pipeif_fetch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipeif_fetch_if.sv
// ----------------------------------------------------------------------------
// pipeif_fetch_if
// Instruction-memory bus between the fetch stage and a variable-latency
// instruction memory.
//   imem_req   : fetch request (fetch -> memory)
//   imem_addr  : 32-bit fetch address (fetch -> memory)
//   imem_ack   : read data valid this cycle, may be combinational with req
//   imem_rdata : 32-bit instruction word (memory -> fetch)
// master = fetch stage, slave = instruction memory.
// ----------------------------------------------------------------------------
interface pipeif_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pipeif_fetch.sv
// ----------------------------------------------------------------------------
// pipeif_fetch
// Instruction-fetch stage of the five-stage pipeline. Owns the PC, selects
// the next PC from decode's pcsource/bpc/jpc/da, fetches through a req/ack
// instruction-memory handshake and drives the IF/ID register (dpc4, inst).
// One-instruction branch delay slot, no flush.
//
// Ports:
//   clock    : pipeline clock, rising edge
//   resetn   : asynchronous active-low reset
//   wpcir    : decode stall, 1 = hold PC and IF/ID
//   pcsource : next-PC select (00 pc+4, 01 bpc, 10 da, 11 jpc)
//   bpc/jpc  : branch / jump targets
//   da       : forwarded rs value, jr target
//   imem     : instruction-memory bus (master side)
//   pc       : current fetch PC
//   dpc4     : IF/ID PC+4
//   inst     : IF/ID instruction, 0 = bubble
// ----------------------------------------------------------------------------
module pipeif_fetch (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 wpcir,
    input  logic [1:0]           pcsource,
    input  logic [31:0]          bpc,
    input  logic [31:0]          jpc,
    input  logic [31:0]          da,
    pipeif_fetch_if.master       imem,
    output logic [31:0]          pc,
    output logic [31:0]          dpc4,
    output logic [31:0]          inst
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_n, dpc4_n, inst_n;
    logic [31:0] hold, hold_n;
    logic        rv, rv_n;
    logic [31:0] rpc, rpc_n;

    logic [31:0] pc4;
    logic [31:0] tgt;
    logic [31:0] npc;
    logic        redirect;

    assign pc4      = pc + 32'd4;
    assign redirect = !wpcir && (pcsource != 2'b00);

    always_comb begin
        tgt = pc4;
        case (pcsource)
            2'b01:   tgt = bpc;
            2'b10:   tgt = da;
            2'b11:   tgt = jpc;
            default: tgt = pc4;
        endcase
    end

    // A deferred redirect wins: it was taken while the delay slot was still
    // outstanding, and that delay slot is what is completing now.
    assign npc = rv ? rpc : (redirect ? tgt : pc4);

    // Request is suppressed during reset so memory never sees a stray fetch.
    assign imem.imem_req  = resetn && (state == FETCH);
    assign imem.imem_addr = pc;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        dpc4_n  = dpc4;
        inst_n  = inst;
        hold_n  = hold;
        rv_n    = rv;
        rpc_n   = rpc;
        case (state)
            FETCH: begin
                if (imem.imem_ack) begin
                    if (!wpcir) begin
                        dpc4_n = pc4;
                        inst_n = imem.imem_rdata;
                        pc_n   = npc;
                        rv_n   = 1'b0;
                    end else begin
                        // Word arrived during a stall: park it and stop
                        // requesting so it is not lost or re-fetched.
                        hold_n  = imem.imem_rdata;
                        state_n = HOLD;
                    end
                end else if (!wpcir) begin
                    inst_n = 32'd0;
                    if (pcsource != 2'b00) begin
                        rv_n  = 1'b1;
                        rpc_n = tgt;
                    end
                end
            end
            HOLD: begin
                if (!wpcir) begin
                    dpc4_n  = pc4;
                    inst_n  = hold;
                    pc_n    = npc;
                    rv_n    = 1'b0;
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= FETCH;
            pc    <= 32'd0;
            dpc4  <= 32'd0;
            inst  <= 32'd0;
            hold  <= 32'd0;
            rv    <= 1'b0;
            rpc   <= 32'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            dpc4  <= dpc4_n;
            inst  <= inst_n;
            hold  <= hold_n;
            rv    <= rv_n;
            rpc   <= rpc_n;
        end
    end

endmodule
